// File: rtl/decoder_scan_if.sv
// Bundle of select-side controls and registered decoder outputs for decoder_scan.
// The master drives enable/mode/select/load; the slave (the decoder) drives d/idx/tick.
interface decoder_scan_if #(
   parameter int N = 3
) ();
   logic             en;
   logic [1:0]       mode;
   logic [N-1:0]     sel;
   logic             load;
   logic [2**N-1:0]  d;
   logic [N-1:0]     idx;
   logic             tick;

   modport master (
      output en, mode, sel, load,
      input  d, idx, tick
   );

   modport slave (
      input  en, mode, sel, load,
      output d, idx, tick
   );
endinterface

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with DIRECT, auto-SCAN and PULSE modes.
// Every output comes straight from a flop so downstream selects never glitch.
module decoder_scan_chk #(
   parameter int N = 3
) (
   input logic            clk,
   input logic            rst_n,
   input logic [2**N-1:0] d,
   input logic [N-1:0]    idx
);
   localparam int W = 2**N;

   a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(d));

   // A live output line must always be the one named by idx.
   a_d_matches_idx : assert property (@(posedge clk) disable iff (!rst_n)
      (d == {W{1'b0}}) || (d == ({{(W-1){1'b0}}, 1'b1} << idx)));
endmodule

module decoder_scan #(
   parameter int N   = 3,
   parameter int DIV = 4
) (
   input logic           clk,
   input logic           rst_n,
   decoder_scan_if.slave bus
);
   localparam int W  = 2**N;
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   typedef enum logic [1:0] {
      MODE_DIRECT = 2'b00,
      MODE_SCAN   = 2'b01,
      MODE_PULSE  = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_e;

   function automatic logic [W-1:0] one_hot(input logic [N-1:0] v);
      logic [W-1:0] r;
      r    = {W{1'b0}};
      r[v] = 1'b1;
      return r;
   endfunction

   logic [W-1:0]  d_r,     d_s;
   logic [N-1:0]  idx_r,   idx_s;
   logic          tick_r,  tick_s;
   logic [PW-1:0] presc_r, presc_s;
   mode_e         prev_mode_r, prev_mode_s;
   mode_e         mode_s;

   assign mode_s = mode_e'(bus.mode);

   // State and output registers; reset wins over every other input.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         d_r         <= {W{1'b0}};
         idx_r       <= {N{1'b0}};
         tick_r      <= 1'b0;
         presc_r     <= {PW{1'b0}};
         prev_mode_r <= MODE_DIRECT;
      end else begin
         d_r         <= d_s;
         idx_r       <= idx_s;
         tick_r      <= tick_s;
         presc_r     <= presc_s;
         prev_mode_r <= prev_mode_s;
      end
   end

   // Next-state decode: idx, prescaler and stored mode hold unless a mode moves them.
   always_comb begin
      d_s         = {W{1'b0}};
      idx_s       = idx_r;
      tick_s      = 1'b0;
      presc_s     = presc_r;
      prev_mode_s = prev_mode_r;
      if (bus.en) begin
         prev_mode_s = mode_s;
         case (mode_s)
            MODE_DIRECT: begin
               d_s   = one_hot(bus.sel);
               idx_s = bus.sel;
            end
            MODE_SCAN: begin
               if (prev_mode_r != MODE_SCAN) begin
                  d_s     = one_hot(bus.sel);
                  idx_s   = bus.sel;
                  presc_s = {PW{1'b0}};
               end else if (presc_r == PRESC_LAST) begin
                  d_s     = one_hot(idx_r + N'(1'b1));
                  idx_s   = idx_r + N'(1'b1);
                  presc_s = {PW{1'b0}};
                  tick_s  = 1'b1;
               end else begin
                  // Rebuild d from idx so a line blanked by en=0 reappears on resume.
                  d_s     = one_hot(idx_r);
                  presc_s = presc_r + PW'(1'b1);
               end
            end
            MODE_PULSE: begin
               if (bus.load) begin
                  d_s   = one_hot(bus.sel);
                  idx_s = bus.sel;
               end else begin
                  d_s   = {W{1'b0}};
               end
            end
            MODE_RSVD: begin
               d_s = {W{1'b0}};
            end
            default: begin
               d_s = {W{1'b0}};
            end
         endcase
      end else begin
         d_s    = {W{1'b0}};
         tick_s = 1'b0;
      end
   end

   assign bus.d    = d_r;
   assign bus.idx  = idx_r;
   assign bus.tick = tick_r;

   decoder_scan_chk #(.N(N)) u_chk (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d_r),
      .idx   (idx_r)
   );
endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan (N=3, DIV=4): vector table plus scan/freeze/reset sequences,
// with expected outputs queued on drive and compared after the clock edge.
module tb_decoder_scan;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   decoder_scan_if #(.N(3)) dsif ();

   decoder_scan #(.N(3), .DIV(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dsif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n;
      logic       en;
      logic [1:0] mode;
      logic [2:0] sel;
      logic       load;
      logic [7:0] d;
      logic [2:0] idx;
      logic       tick;
      string      name;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      logic [2:0] idx;
      logic       tick;
      string      name;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic e, input logic [1:0] m,
                               input logic [2:0] s, input logic l, input logic [7:0] ed,
                               input logic [2:0] ei, input logic et, input string nm);
      vec_t v;
      v.rst_n = r; v.en = e; v.mode = m; v.sel = s; v.load = l;
      v.d = ed; v.idx = ei; v.tick = et; v.name = nm;
      return v;
   endfunction

   function automatic logic [7:0] oh(input int i);
      logic [7:0] r;
      r = 8'h00;
      r[i % 8] = 1'b1;
      return r;
   endfunction

   task automatic check_out();
      exp_t x;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: no expected entry queued at time %0t", $time);
      end else begin
         x = sb.pop_front();
         checks++;
         if (dsif.d !== x.d || dsif.idx !== x.idx || dsif.tick !== x.tick) begin
            errors++;
            $display("FAIL %s: got d=%h idx=%0d tick=%b, expected d=%h idx=%0d tick=%b",
                     x.name, dsif.d, dsif.idx, dsif.tick, x.d, x.idx, x.tick);
         end
      end
   endtask

   task automatic step(input vec_t v);
      exp_t x;
      rst_n     = v.rst_n;
      dsif.en   = v.en;
      dsif.mode = v.mode;
      dsif.sel  = v.sel;
      dsif.load = v.load;
      x.d = v.d; x.idx = v.idx; x.tick = v.tick; x.name = v.name;
      sb.push_back(x);
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0; dsif.en = 1'b1; dsif.mode = 2'b01; dsif.sel = 3'd3; dsif.load = 1'b0;

      // Reset, DIRECT sweep, en drop, PULSE and reserved mode
      tbl.push_back(mk(1'b0, 1'b1, 2'b01, 3'd3, 1'b0, 8'h00, 3'd0, 1'b0, "reset_0"));
      tbl.push_back(mk(1'b0, 1'b1, 2'b01, 3'd3, 1'b0, 8'h00, 3'd0, 1'b0, "reset_1"));
      tbl.push_back(mk(1'b1, 1'b1, 2'b00, 3'd5, 1'b0, 8'h20, 3'd5, 1'b0, "direct_after_reset"));
      for (int s = 0; s < 8; s++)
         tbl.push_back(mk(1'b1, 1'b1, 2'b00, 3'(s), 1'b0, oh(s), 3'(s), 1'b0, "direct_sweep"));
      tbl.push_back(mk(1'b1, 1'b0, 2'b00, 3'd2, 1'b0, 8'h00, 3'd7, 1'b0, "direct_en_low"));
      tbl.push_back(mk(1'b1, 1'b1, 2'b10, 3'd3, 1'b1, 8'h08, 3'd3, 1'b0, "pulse_single"));
      tbl.push_back(mk(1'b1, 1'b1, 2'b10, 3'd6, 1'b0, 8'h00, 3'd3, 1'b0, "pulse_end"));
      tbl.push_back(mk(1'b1, 1'b1, 2'b10, 3'd1, 1'b1, 8'h02, 3'd1, 1'b0, "pulse_b2b_1"));
      tbl.push_back(mk(1'b1, 1'b1, 2'b10, 3'd2, 1'b1, 8'h04, 3'd2, 1'b0, "pulse_b2b_2"));
      tbl.push_back(mk(1'b1, 1'b1, 2'b10, 3'd4, 1'b1, 8'h10, 3'd4, 1'b0, "pulse_b2b_3"));
      tbl.push_back(mk(1'b1, 1'b1, 2'b10, 3'd0, 1'b0, 8'h00, 3'd4, 1'b0, "pulse_idle"));
      tbl.push_back(mk(1'b1, 1'b1, 2'b11, 3'd1, 1'b1, 8'h00, 3'd4, 1'b0, "reserved"));
      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i]);

      // SCAN entry at 6 (previous mode reserved), sel scrambled after entry
      for (int k = 0; k < 50; k++) begin
         logic [2:0] s;
         s = (k == 0) ? 3'd6 : 3'($urandom_range(7, 0));
         step(mk(1'b1, 1'b1, 2'b01, s, 1'b0, oh(6 + k / 4), 3'((6 + k / 4) % 8),
                 (k > 0 && k % 4 == 0), "scan_wrap"));
      end

      // Now idx=2 with prescaler=1: freeze for 5 cycles, then resume
      for (int k = 0; k < 5; k++)
         step(mk(1'b1, 1'b0, 2'b01, 3'd7, 1'b0, 8'h00, 3'd2, 1'b0, "scan_freeze"));
      step(mk(1'b1, 1'b1, 2'b01, 3'd7, 1'b0, 8'h04, 3'd2, 1'b0, "scan_resume_0"));
      step(mk(1'b1, 1'b1, 2'b01, 3'd7, 1'b0, 8'h04, 3'd2, 1'b0, "scan_resume_1"));
      step(mk(1'b1, 1'b1, 2'b01, 3'd7, 1'b0, 8'h08, 3'd3, 1'b1, "scan_resume_adv"));
      for (int j = 1; j <= 8; j++)
         step(mk(1'b1, 1'b1, 2'b01, 3'd0, 1'b0, oh(3 + j / 4), 3'(3 + j / 4),
                 (j % 4 == 0), "scan_to_5"));

      // Reset mid-scan, then SCAN -> DIRECT -> SCAN re-entry clears the prescaler
      step(mk(1'b0, 1'b1, 2'b01, 3'd6, 1'b0, 8'h00, 3'd0, 1'b0, "reset_mid_scan"));
      step(mk(1'b1, 1'b1, 2'b01, 3'd1, 1'b0, 8'h02, 3'd1, 1'b0, "scan_entry_after_reset"));
      step(mk(1'b1, 1'b1, 2'b01, 3'd5, 1'b0, 8'h02, 3'd1, 1'b0, "scan_hold_after_reset"));
      step(mk(1'b1, 1'b1, 2'b00, 3'd4, 1'b0, 8'h10, 3'd4, 1'b0, "leave_scan_direct"));
      step(mk(1'b1, 1'b1, 2'b01, 3'd4, 1'b0, 8'h10, 3'd4, 1'b0, "scan_reentry"));
      for (int j = 1; j <= 3; j++)
         step(mk(1'b1, 1'b1, 2'b01, 3'd2, 1'b0, 8'h10, 3'd4, 1'b0, "scan_reentry_dwell"));
      step(mk(1'b1, 1'b1, 2'b01, 3'd2, 1'b0, 8'h20, 3'd5, 1'b1, "scan_reentry_adv"));

      // Reset during a pulse aborts it
      step(mk(1'b1, 1'b1, 2'b10, 3'd7, 1'b1, 8'h80, 3'd7, 1'b0, "pulse_pre_reset"));
      step(mk(1'b0, 1'b1, 2'b10, 3'd6, 1'b1, 8'h00, 3'd0, 1'b0, "reset_mid_pulse"));

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
